// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch sequencer
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch FSM states. At most one memory request is outstanding at a time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  // Size of one instruction word in bytes; the sequential PC stride.
  localparam logic [31:0] INST_BYTES = 32'd4;

  // PC loaded by reset unless the instantiating level overrides it.
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program counter register with load enable
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,      // synchronous, active-low
  input  logic        load_en_i,
  input  logic [31:0] next_pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  // PC holds its value unless a load is requested; reset restores the vector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
    end else if (load_en_i) begin
      pc_q <= next_pc_i;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Single-outstanding instruction fetch FSM with redirect,
//               halt and misaligned-target reporting
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,          // synchronous, active-low
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        misaligned_err
);

  fetch_state_e state_q, state_d;
  logic         drop_q, drop_d;     // a redirect made the outstanding response stale
  logic         rsp_accept;         // a valid, non-stale response is captured this edge
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         pc_load;
  logic [31:0]  inst_data_q;
  logic [31:0]  inst_pc_q;
  logic         misaligned_q;
  logic [31:0]  redirect_aligned;

  // Redirect targets are forced onto a word boundary; low bits only feed the error flag.
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // Redirect wins over the sequential increment; the PC only moves on those two events.
  always_comb begin
    pc_load = redirect_valid | rsp_accept;
    pc_d    = redirect_valid ? redirect_aligned : (pc_q + INST_BYTES);
  end

  fetch_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load_en_i (pc_load),
    .next_pc_i (pc_d),
    .pc_o      (pc_q)
  );

  // FSM state and stale-response flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic: redirects are evaluated first in every state that cares.
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    rsp_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A redirect here only moves the PC; halt alone decides when to leave.
        if (!halt) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Once presented, the request stays up until accepted regardless of halt.
        if (imem_req_ready) begin
          state_d = ST_WAIT;
          // Accepted with the pre-redirect address: its response must be thrown away.
          if (redirect_valid) begin
            drop_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          if (imem_rsp_valid) begin
            // Response coincides with the redirect: discard it and refetch now.
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d    = ST_HOLD;
            rsp_accept = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          state_d = ST_REQ;
        end else if (inst_ready) begin
          state_d = halt ? ST_IDLE : ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Capture the fetched word with its PC, and register the misaligned-target pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inst_data_q  <= 32'h0;
      inst_pc_q    <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      if (rsp_accept) begin
        inst_data_q <= imem_rsp_data;
        inst_pc_q   <= pc_q;
      end
      misaligned_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);
    end
  end

  // Handshake outputs are pure decodes of the current state.
  always_comb begin
    imem_req_valid = (state_q == ST_REQ);
    imem_req_addr  = pc_q;
    inst_valid     = (state_q == ST_HOLD);
    inst_data      = inst_data_q;
    inst_pc        = inst_pc_q;
    misaligned_err = misaligned_q;
  end

endmodule
`default_nettype wire
